mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single shared 16-bit memory port of the multicycle CPU. It serialises instruction-fetch requests (IF state) and data requests (LWD/SWD MEM state) onto one memory with variable latency, and drives the memory strobes, address and write data. It returns a one-cycle acknowledge with registered read data to the winning requester. A watchdog aborts transactions the memory never completes.

---
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port arbiter/sequencer for the single shared memory port
//               of the multicycle CPU. Serialises instruction-fetch and data
//               (load/store) requests onto a variable-latency memory, returns
//               a one-cycle ack with registered read data, and aborts any
//               transaction the memory never completes (watchdog).
//               Optional feature macro: ARB_ROUND_ROBIN_EN
//                 defined   -> ties alternate between ports (round robin)
//                 undefined -> data port wins every tie
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int WORD_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic              i_ack,
  output logic [WORD_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [WORD_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  // Counter wide enough to hold TIMEOUT; one extra bit on the incremented value
  localparam int              CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0]  c_TIMEOUT = TIMEOUT[CNT_W:0];
  localparam logic            c_FETCH   = 1'b0;
  localparam logic            c_DATA    = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state, w_state_nx;
  logic               r_grant, w_grant_nx;
  logic               r_we, w_we_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [CNT_W:0]     w_cnt_inc;
  logic               w_timeout;
  logic               w_done;
  logic               w_pick;
  logic               w_read_nx, w_write_nx;
  logic [WORD_W-1:0]  w_addr_nx, w_wdata_nx, w_i_data_nx, w_d_rdata_nx;
  logic               w_i_ack_nx, w_d_ack_nx, w_err_nx, w_busy_nx;
`ifdef ARB_ROUND_ROBIN_EN
  logic               r_last_grant, w_last_nx;
`endif

  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  // Abort on the BUSY cycle whose increment would reach TIMEOUT, so the ack
  // lands in cycle TIMEOUT+1 counting the request cycle as cycle 0.
  assign w_timeout = (TIMEOUT != 0) && !mem_ready && (w_cnt_inc == c_TIMEOUT);
  assign w_done    = mem_ready || w_timeout;

  // Port selection in IDLE: a lone request wins outright; ties go by config
`ifdef ARB_ROUND_ROBIN_EN
  assign w_pick = (i_req && d_req) ? ~r_last_grant : d_req;
`else
  assign w_pick = d_req;
`endif

  // Next-state and next-output logic; everything defaults to hold
  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_we_nx      = r_we;
    w_cnt_nx     = r_cnt;
    w_read_nx    = mem_read;
    w_write_nx   = mem_write;
    w_addr_nx    = mem_addr;
    w_wdata_nx   = mem_wdata;
    w_i_data_nx  = i_data;
    w_d_rdata_nx = d_rdata;
    w_i_ack_nx   = 1'b0;
    w_d_ack_nx   = 1'b0;
    w_err_nx     = 1'b0;
    w_busy_nx    = busy;
`ifdef ARB_ROUND_ROBIN_EN
    w_last_nx    = r_last_grant;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_grant_nx = w_pick;
          w_addr_nx  = (w_pick == c_DATA) ? d_addr : i_addr;
          if (w_pick == c_DATA) begin
            w_wdata_nx = d_wdata;
            w_we_nx    = d_we;
          end
          w_read_nx  = (w_pick == c_FETCH) || !d_we;
          w_write_nx = (w_pick == c_DATA) && d_we;
          w_cnt_nx   = '0;
          w_busy_nx  = 1'b1;
          w_state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!mem_ready) begin
          w_cnt_nx = w_cnt_inc[CNT_W-1:0];
        end
        if (w_done) begin
          w_read_nx  = 1'b0;
          w_write_nx = 1'b0;
          w_err_nx   = !mem_ready;
          w_i_ack_nx = (r_grant == c_FETCH);
          w_d_ack_nx = (r_grant == c_DATA);
          if (r_grant == c_FETCH) begin
            w_i_data_nx = mem_ready ? mem_rdata : {WORD_W{1'b1}};
          end else if (!mem_ready) begin
            w_d_rdata_nx = {WORD_W{1'b1}};
          end else if (!r_we) begin
            w_d_rdata_nx = mem_rdata;
          end
          w_state_nx = S_RESP;
        end
      end
      S_RESP: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        w_last_nx  = r_grant;
`endif
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops the strobes immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_grant      <= c_FETCH;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_data       <= '0;
      d_rdata      <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_grant <= c_FETCH;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_grant      <= w_grant_nx;
      r_we         <= w_we_nx;
      r_cnt        <= w_cnt_nx;
      mem_read     <= w_read_nx;
      mem_write    <= w_write_nx;
      mem_addr     <= w_addr_nx;
      mem_wdata    <= w_wdata_nx;
      i_data       <= w_i_data_nx;
      d_rdata      <= w_d_rdata_nx;
      i_ack        <= w_i_ack_nx;
      d_ack        <= w_d_ack_nx;
      err          <= w_err_nx;
      busy         <= w_busy_nx;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_grant <= w_last_nx;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Stimulus pushes the
//               expected ack (port, data, err) into a scoreboard queue; a
//               monitor pops and compares on every ack. Cycle-level strobe
//               and timing checks are made by the stimulus itself.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_req, d_req, d_we, mem_ready;
  logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic         i_ack, d_ack, err, mem_read, mem_write, busy;
  logic [W-1:0] i_data, d_rdata, mem_addr, mem_wdata;

  typedef struct {
    bit           is_d;
    logic [W-1:0] data;
    bit           err;
  } exp_t;

  exp_t         sb[$];
  exp_t         me;
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] model_drdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in the current (IDLE) cycle.
  // waits >= 0: mem_ready in cycle waits+1; waits < 0: never ready (timeout).
  task automatic txn(input bit is_d, input bit we, input logic [W-1:0] addr,
                     input logic [W-1:0] wdata, input logic [W-1:0] rdata,
                     input int waits);
    int           busy_len;
    bit           to;
    bit           wr;
    exp_t         e;
    logic [W-1:0] ed;
    to       = (waits < 0);
    wr       = is_d && we;
    busy_len = to ? TO : waits + 1;
    if (to)      ed = 16'hFFFF;
    else if (wr) ed = model_drdata;
    else         ed = rdata;
    if (is_d) model_drdata = ed;
    e.is_d = is_d; e.data = ed; e.err = to;
    sb.push_back(e);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    chk("c0_no_strobe", {30'b0, mem_read, mem_write}, 32'd0);
    for (int c = 1; c <= busy_len; c++) begin
      tick();
      chk("busy_strobes", {30'b0, mem_read, mem_write}, {30'b0, ~wr, wr});
      chk("busy_addr", {16'b0, mem_addr}, {16'b0, addr});
      if (wr) chk("busy_wdata", {16'b0, mem_wdata}, {16'b0, wdata});
      chk("busy_flag_no_ack", {29'b0, busy, i_ack, d_ack}, 32'd4);
      if (c == busy_len && !to) begin
        mem_ready = 1'b1; mem_rdata = rdata;
      end else begin
        mem_rdata = 16'hDEAD;
      end
    end
    tick();
    mem_ready = 1'b0; mem_rdata = 16'hBEEF;
    chk("resp_ack", {30'b0, i_ack, d_ack}, {30'b0, ~is_d, is_d});
    chk("resp_err", {31'b0, err}, {31'b0, to});
    chk("resp_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    chk("idle_after_ack", {29'b0, busy, i_ack, d_ack}, 32'd0);
  endtask

  // Scoreboard monitor: every ack pops one expected response
  always @(negedge clk) begin
    if (reset_n && (i_ack || d_ack)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", {30'b0, i_ack, d_ack}, 32'd0);
      end else begin
        me = sb.pop_front();
        chk("sb_port", {30'b0, i_ack, d_ack}, {30'b0, ~me.is_d, me.is_d});
        chk("sb_data", {16'b0, (me.is_d ? d_rdata : i_data)}, {16'b0, me.data});
        chk("sb_err", {31'b0, err}, {31'b0, me.err});
      end
    end
  end

  // Hard bound on total run time
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    exp_t e;
    bit   g;
    int   acks;
`ifdef ARB_ROUND_ROBIN_EN
    bit   last;
`endif
    reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_flags", {26'b0, i_ack, d_ack, err, mem_read, mem_write, busy}, 32'd0);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
    chk("rst_data", {i_data, d_rdata}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Fetch, 2 wait cycles
    txn(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 2);
    // Store, zero-wait (captured read data must not land in d_rdata)
    txn(1'b1, 1'b1, 16'h0040, 16'h1234, 16'h9999, 0);
    // Data read, 1 wait cycle
    txn(1'b1, 1'b0, 16'h0080, 16'h0000, 16'h5A5A, 1);
    // Store after load: d_rdata must keep the loaded word
    txn(1'b1, 1'b1, 16'h0044, 16'h4321, 16'h7777, 1);

    // Simultaneous requests held for four transactions
    mem_rdata = 16'h7E7E; mem_ready = 1'b1; d_we = 1'b0;
    d_addr = 16'h0100; i_addr = 16'h0200;
`ifdef ARB_ROUND_ROBIN_EN
    last = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      g = ~last; last = g;
`else
      g = 1'b1;
`endif
      e.is_d = g; e.data = 16'h7E7E; e.err = 1'b0;
      sb.push_back(e);
      if (g) model_drdata = 16'h7E7E;
    end
    i_req = 1'b1; d_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      tick();
      if (i_ack || d_ack) acks++;
    end
    chk("tie_ack_count", acks, 32'd4);
    tick();
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Watchdog abort, then a normal transaction
    txn(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, -1);
    txn(1'b0, 1'b0, 16'h0022, 16'h0000, 16'h3C3C, 0);

    // Reset pulled mid-transaction
    i_req = 1'b1; i_addr = 16'h0300; mem_ready = 1'b0;
    tick();
    chk("rst_mid_pre_strobe", {31'b0, mem_read}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_async_drop", {30'b0, mem_read, busy}, 32'd0);
    i_req = 1'b0;
    repeat (2) begin
      tick();
      chk("rst_mid_no_ack", {30'b0, i_ack, d_ack}, 32'd0);
    end
    reset_n = 1'b1;
    tick();
    chk("rst_mid_idle", {29'b0, busy, mem_read, mem_write}, 32'd0);
    txn(1'b0, 1'b0, 16'h0300, 16'h0000, 16'h1111, 1);

    // mem_ready pulse while IDLE must be ignored
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    txn(1'b1, 1'b0, 16'h0500, 16'h0000, 16'h2222, 2);

    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
